// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions.
// Contents: the schedule word type, the key_size encoding, the Nk/Nr lookups,
// storage-depth helpers, and the GF(2^8) primitives used by the key schedule
// and by the S-box.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        KS_128  = 2'b00,
        KS_192  = 2'b01,
        KS_256  = 2'b10,
        KS_RSVD = 2'b11
    } key_size_e;

    // Number of 32-bit key words (Nk). The reserved code returns 0.
    function automatic logic [3:0] nk_of(input key_size_e ks);
        case (ks)
            KS_128:  return 4'd4;
            KS_192:  return 4'd6;
            KS_256:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Number of rounds (Nr). The reserved code returns 0.
    function automatic logic [3:0] nr_of(input key_size_e ks);
        case (ks)
            KS_128:  return 4'd10;
            KS_192:  return 4'd12;
            KS_256:  return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

    // Nr = Nk + 6 for every AES key size.
    function automatic int max_nr(input int max_key_bits);
        return max_key_bits / 32 + 6;
    endfunction

    function automatic int words_of(input int nr);
        return 4 * (nr + 1);
    endfunction

    // Multiply by x in GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, computed rather than tabulated.
// Ports: a - input byte; s - substituted byte.
// The inverse is a^254 (0 maps to 0), built as the product of the squares
// a^2 * a^4 * ... * a^128. The affine transform follows it.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    logic [7:0] inv;
    logic [7:0] sq;

    always_comb begin
        inv = 8'h01;
        sq  = a;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Ports: data - input word; result - byte-wise substituted word.
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t data,
    output word_t result
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .a (data[8*gi +: 8]),
                .s (result[8*gi +: 8])
            );
        end
    endgenerate

endmodule

// File: rtl/aes_key_expander.sv
// AES key-schedule generator for 128/192/256-bit keys, with the key size
// selected at run time. A load writes the Nk key words. The FSM then writes
// one schedule word per cycle into a register file. Any round key can be read
// combinationally by round index.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   key_in/key_size    - MSB-aligned key and its size code, sampled on accept
//   key_valid/key_ready- load handshake (key_ready low while expanding)
//   key_clear          - zeroise storage and return to idle
//   rd_round/rd_key    - round-key read port (zero above num_rounds)
//   keys_valid, busy   - schedule complete / expansion in progress
//   num_rounds         - Nr of the loaded key, 0 when none is loaded
//   key_err            - one-cycle pulse on accepting an unsupported size
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] key_in,
    input  logic [1:0]   key_size,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic         key_clear,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key,
    output logic         keys_valid,
    output logic [3:0]   num_rounds,
    output logic         busy,
    output logic         key_err
);

    localparam int MAX_NR = max_nr(MAX_KEY_BITS);
    localparam int DEPTH  = words_of(MAX_NR);
    localparam int IW     = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_e;

    state_e        state_reg;
    word_t         w_reg [DEPTH];
    logic [IW-1:0] i_reg;
    logic [IW-1:0] last_reg;
    logic [2:0]    mod_reg;
    logic [7:0]    rcon_reg;
    logic [3:0]    nk_reg;
    logic [3:0]    nr_reg;
    logic          keys_valid_reg;
    logic          key_err_reg;

    key_size_e     ks;
    logic [3:0]    ld_nk;
    logic          ld_ok;
    logic          accept;

    assign ks     = key_size_e'(key_size);
    assign ld_nk  = nk_of(ks);
    assign ld_ok  = (ld_nk != 4'd0) && (int'(ld_nk) * 32 <= MAX_KEY_BITS);
    // A clear in the same cycle wins and the load is simply dropped.
    assign accept = key_valid && key_ready && !key_clear;

    // Next-word datapath. RotWord is only applied on the i mod Nk == 0 step;
    // the S-box is shared between that step and the AES-256 midpoint step.
    word_t prev_word, back_word, sw_in, sw_out, temp_word;
    logic  mod_zero;

    assign mod_zero  = (mod_reg == 3'd0);
    assign prev_word = w_reg[i_reg - IW'(1)];
    assign back_word = w_reg[i_reg - IW'(nk_reg)];
    assign sw_in     = mod_zero ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_sub_word u_sub_word (
        .data   (sw_in),
        .result (sw_out)
    );

    always_comb begin
        temp_word = prev_word;
        if (mod_zero)
            temp_word = sw_out ^ {rcon_reg, 24'h0};
        else if (nk_reg == 4'd8 && mod_reg == 3'd4)
            temp_word = sw_out;
    end

    always_ff @(posedge clk) begin
        if (rst || key_clear) begin
            state_reg      <= S_IDLE;
            for (int k = 0; k < DEPTH; k++) w_reg[k] <= '0;
            i_reg          <= '0;
            last_reg       <= '0;
            mod_reg        <= '0;
            rcon_reg       <= 8'h01;
            nk_reg         <= '0;
            nr_reg         <= '0;
            keys_valid_reg <= 1'b0;
            key_err_reg    <= 1'b0;
        end else begin
            key_err_reg <= 1'b0;
            if (accept) begin
                if (ld_ok) begin
                    for (int k = 0; k < 8; k++) begin
                        if (k < int'(ld_nk)) w_reg[k] <= key_in[255-32*k -: 32];
                    end
                    i_reg          <= IW'(ld_nk);
                    last_reg       <= IW'({nr_of(ks), 2'b00} + 6'd3);
                    mod_reg        <= '0;
                    rcon_reg       <= 8'h01;
                    nk_reg         <= ld_nk;
                    nr_reg         <= nr_of(ks);
                    keys_valid_reg <= 1'b0;
                    state_reg      <= S_EXPAND;
                end else begin
                    key_err_reg <= 1'b1;
                end
            end else if (state_reg == S_EXPAND) begin
                w_reg[i_reg] <= back_word ^ temp_word;
                i_reg        <= i_reg + IW'(1);
                mod_reg      <= ({1'b0, mod_reg} == nk_reg - 4'd1) ? 3'd0 : mod_reg + 3'd1;
                if (mod_zero) rcon_reg <= xtime(rcon_reg);
                if (i_reg == last_reg) begin
                    state_reg      <= S_DONE;
                    keys_valid_reg <= 1'b1;
                end
            end
        end
    end

    // Round-key read. The index is forced in range when the round is above
    // num_rounds, so the array is never addressed past its end.
    logic          rd_ok;
    logic [IW-1:0] rd_base;

    assign rd_ok   = (rd_round <= nr_reg);
    assign rd_base = rd_ok ? IW'({rd_round, 2'b00}) : '0;
    assign rd_key  = rd_ok ? {w_reg[rd_base], w_reg[rd_base + IW'(1)],
                              w_reg[rd_base + IW'(2)], w_reg[rd_base + IW'(3)]} : '0;

    assign key_ready  = (state_reg != S_EXPAND);
    assign busy       = (state_reg == S_EXPAND);
    assign keys_valid = keys_valid_reg;
    assign num_rounds = nr_reg;
    assign key_err    = key_err_reg;

endmodule
